// File: rtl/countdown_decrementer_pkg.sv
// Shared definitions for the interval countdown: word width and the
// controller state encodings. Encoding 2'd3 is illegal and recovers to idle.
package countdown_decrementer_pkg;

    localparam int WORD_LENGTH = 32;

    typedef enum logic [1:0] {
        CD_IDLE    = 2'd0,
        CD_RUN     = 2'd1,
        CD_EXPIRED = 2'd2,
        CD_ILLEGAL = 2'd3
    } cd_state_t;

endpackage : countdown_decrementer_pkg

// File: rtl/countdown_decrementer_if.sv
// Control/status bundle between the register block (master) and the
// countdown (slave). Data words use bit 0 as the MSB.
interface countdown_decrementer_if #(
    parameter int W = countdown_decrementer_pkg::WORD_LENGTH
) ();

    logic         ld;
    logic [0:W-1] ld_val;
    logic         tick;
    logic         ack;
    logic [0:W-1] cnt;
    logic         busy;
    logic         zero;
    logic         expire;
    logic         pending;

    modport master (
        output ld, ld_val, tick, ack,
        input  cnt, busy, zero, expire, pending
    );

    modport slave (
        input  ld, ld_val, tick, ack,
        output cnt, busy, zero, expire, pending
    );

endinterface : countdown_decrementer_if

// File: rtl/countdown_decrementer_word_decrementer.sv
// Combinational word decrementer: s = a - 1 over W bits, borrow set only
// when a is zero. Counterpart of the word incrementer.
module word_decrementer
    import countdown_decrementer_pkg::*;
#(
    parameter int W = WORD_LENGTH
) (
    input  logic [0:W-1] a,
    output logic [0:W-1] s,
    output logic         borrow
);

    assign s      = a - W'(1);
    assign borrow = (a == '0);

endmodule : word_decrementer

// File: rtl/countdown_decrementer.sv
// Loadable interval countdown. Decrements once per qualified tick, pulses
// expire for one cycle on reaching zero and holds a sticky pending flag
// until acknowledged. Priority: rst > ld > ack > tick.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: a reload register captures
// ld_val on every load; on expiry a non-zero reload restarts the count
// and the controller stays in RUN.
//
// state      | meaning
// -----------+-----------------------------------------------------
// CD_IDLE    | counter stopped, ticks ignored
// CD_RUN     | counting down on tick
// CD_EXPIRED | reached zero, cnt held at 0 until ack or ld
// CD_ILLEGAL | unreachable encoding, returns to CD_IDLE
module countdown_decrementer
    import countdown_decrementer_pkg::*;
#(
    parameter int W = WORD_LENGTH
) (
    input logic                     clk,
    input logic                     rst,
    countdown_decrementer_if.slave  bus
);

    cd_state_t    state_q, state_n;
    logic [0:W-1] cnt_q, cnt_n;
    logic         zero_q, zero_n;
    logic         expire_q, expire_n;
    logic         pending_q, pending_n;
    logic [0:W-1] dec_val;
    logic         dec_borrow;
    logic         dec_apply;
    logic [0:W-1] restart_val;

    word_decrementer #(.W(W)) u_dec (
        .a      (cnt_q),
        .s      (dec_val),
        .borrow (dec_borrow)
    );

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [0:W-1] reload_q;

    // Reload value tracks every load and clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else if (bus.ld) begin
            reload_q <= bus.ld_val;
        end
    end

    assign restart_val = reload_q;
`else
    assign restart_val = '0;
`endif

    // Only a plain tick in RUN with no load/ack takes the decrement path.
    assign dec_apply = (state_q == CD_RUN) && bus.tick && !bus.ld && !bus.ack;

    // Next-state, next-count and flag logic in priority order ld > ack > tick.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        expire_n  = 1'b0;
        pending_n = pending_q;

        if (bus.ld) begin
            cnt_n   = bus.ld_val;
            state_n = (bus.ld_val != '0) ? CD_RUN : CD_IDLE;
            if (bus.ack) begin
                pending_n = 1'b0;
            end
        end else if (bus.ack) begin
            pending_n = 1'b0;
            if (state_q == CD_EXPIRED) begin
                state_n = CD_IDLE;
            end else if (state_q == CD_ILLEGAL) begin
                state_n = CD_IDLE;
                cnt_n   = '0;
            end
        end else begin
            case (state_q)
                CD_IDLE: begin
                end
                CD_RUN: begin
                    if (bus.tick) begin
                        if (cnt_q == W'(1)) begin
                            expire_n  = 1'b1;
                            pending_n = 1'b1;
                            if (restart_val != '0) begin
                                cnt_n = restart_val;
                            end else begin
                                cnt_n   = '0;
                                state_n = CD_EXPIRED;
                            end
                        end else begin
                            cnt_n = dec_val;
                        end
                    end
                end
                CD_EXPIRED: begin
                    cnt_n = '0;
                end
                default: begin
                    state_n = CD_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end

        zero_n = (cnt_n == '0);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CD_IDLE;
            cnt_q     <= '0;
            zero_q    <= 1'b1;
            expire_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            zero_q    <= zero_n;
            expire_q  <= expire_n;
            pending_q <= pending_n;
        end
    end

    // RUN never holds zero, so the decrementer must never borrow when used.
    a_no_borrow : assert property (@(posedge clk) disable iff (rst)
        dec_apply |-> !dec_borrow);

    assign bus.cnt     = cnt_q;
    assign bus.busy    = (state_q == CD_RUN);
    assign bus.zero    = zero_q;
    assign bus.expire  = expire_q;
    assign bus.pending = pending_q;

endmodule : countdown_decrementer

// File: tb/tb_countdown_decrementer.sv
// Bench for countdown_decrementer: directed scenarios then random traffic,
// compared against a cycle-level reference model through a scoreboard queue.
// Honours COUNTDOWN_AUTO_RELOAD_EN in the reference model.
module tb_countdown_decrementer;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] cnt;
        logic         busy;
        logic         zero;
        logic         expire;
        logic         pending;
    } exp_t;

    logic clk;
    logic rst;

    countdown_decrementer_if #(.W(W)) bus ();

    countdown_decrementer #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [0:W-1] ut_a;
    logic [0:W-1] ut_s;
    logic         ut_b;

    word_decrementer #(.W(W)) u_ut (
        .a      (ut_a),
        .s      (ut_s),
        .borrow (ut_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    logic [W-1:0] m_cnt;
    logic         m_active;
    logic         m_pending;
    logic [W-1:0] m_reload;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a counting flag, a count and a pending flag; one call per clock.
    task automatic step(input logic r, input logic l, input logic [W-1:0] v,
                        input logic t, input logic a);
        exp_t e;
        logic exp_pulse;
        @(negedge clk);
        rst        = r;
        bus.ld     = l;
        bus.ld_val = v;
        bus.tick   = t;
        bus.ack    = a;
        exp_pulse  = 1'b0;
        if (r) begin
            m_cnt     = 0;
            m_active  = 0;
            m_pending = 0;
            m_reload  = 0;
        end else if (l) begin
            m_cnt    = v;
            m_active = (v != 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            m_reload = v;
`endif
            if (a) m_pending = 0;
        end else if (a) begin
            m_pending = 0;
        end else if (t && m_active) begin
            if (m_cnt == 1) begin
                exp_pulse = 1;
                m_pending = 1;
                if (m_reload != 0) begin
                    m_cnt = m_reload;
                end else begin
                    m_cnt    = 0;
                    m_active = 0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        e.cnt     = m_cnt;
        e.busy    = m_active;
        e.zero    = (m_cnt == 0);
        e.expire  = exp_pulse;
        e.pending = m_pending;
        sb_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
    endtask

    // Monitor: after each rising edge compare the DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("cnt",     bus.cnt,     e.cnt);
                chk("busy",    W'(bus.busy),    W'(e.busy));
                chk("zero",    W'(bus.zero),    W'(e.zero));
                chk("expire",  W'(bus.expire),  W'(e.expire));
                chk("pending", W'(bus.pending), W'(e.pending));
            end
        end
    end

    // Stimulus: sub-module unit test, directed scenarios, then random traffic.
    initial begin
        int budget;
        rst        = 1'b1;
        bus.ld     = 1'b0;
        bus.ld_val = '0;
        bus.tick   = 1'b0;
        bus.ack    = 1'b0;
        m_cnt      = 0;
        m_active   = 0;
        m_pending  = 0;
        m_reload   = 0;

        ut_a = 32'h0000_0000; #1;
        chk("dec_s_0", ut_s, 32'hFFFF_FFFF);
        chk("dec_b_0", W'(ut_b), 32'd1);
        ut_a = 32'd10; #1;
        chk("dec_s_10", ut_s, 32'd9);
        chk("dec_b_10", W'(ut_b), 32'd0);
        ut_a = 32'hFFFF_FFFF; #1;
        chk("dec_s_max", ut_s, 32'hFFFF_FFFE);
        chk("dec_b_max", W'(ut_b), 32'd0);

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        step(0, 1, 5, 0, 0);
        ticks(5);
        ticks(3);

        step(0, 1, 3, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        ticks(4);
        step(0, 0, 0, 0, 1);

        step(0, 1, 0, 1, 0);
        ticks(2);
        step(0, 1, 32'hFFFF_FFFF, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 7, 0, 1);
        ticks(3);
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        step(0, 1, 2, 0, 0);
        ticks(2);
        step(0, 0, 0, 0, 1);
        ticks(4);
        step(0, 0, 0, 0, 1);
        ticks(2);
        step(1, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            logic         r, l, t, a;
            logic [W-1:0] v;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 7))
                0:       v = $urandom;
                1:       v = 0;
                2:       v = 32'hFFFF_FFFF;
                default: v = W'($urandom_range(1, 6));
            endcase
            step(r, l, v, t, a);
        end

        step(0, 0, 0, 0, 0);
        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_countdown_decrementer
